// File: rtl/game_flow_if.sv
// Event pulses from the button/mouse decoder and collision logic, plus the
// registered status bundle that feeds the overlay renderer.
interface game_flow_if;
  logic       stage_sel_pulse;
  logic [1:0] stage_sel;
  logic       staff_pulse;
  logic       next_pulse;
  logic       back_pulse;
  logic       retry_pulse;
  logic       key_hit;
  logic       light_hit;
  logic       door_hit;
  logic       trap_hit;
  logic [3:0] state;
  logic [1:0] key_find;
  logic [1:0] heart;
  logic [1:0] todo;
  logic [3:0] play_valid;

  modport master (
    output stage_sel_pulse, stage_sel, staff_pulse, next_pulse, back_pulse,
           retry_pulse, key_hit, light_hit, door_hit, trap_hit,
    input  state, key_find, heart, todo, play_valid
  );

  modport slave (
    input  stage_sel_pulse, stage_sel, staff_pulse, next_pulse, back_pulse,
           retry_pulse, key_hit, light_hit, door_hit, trap_hit,
    output state, key_find, heart, todo, play_valid
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: screen state, stage progress, hearts with trap
// cooldown and the stage-unlock mask, all registered for the overlay.
module game_flow_ctrl #(
  parameter int HEARTS       = 3,
  parameter int KEYS_NEEDED  = 3,
  parameter int HIT_COOLDOWN = 50000000,
  parameter int CD_W         = 26
) (
  input logic        clk,
  input logic        rst,
  game_flow_if.slave bus
);

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    TODO_NONE       = 2'd0,
    TODO_FIND_KEY   = 2'd1,
    TODO_FIND_LIGHT = 2'd2,
    TODO_FIND_DOOR  = 2'd3
  } todo_e;

  localparam logic [1:0]      HEARTS_V = 2'(HEARTS);
  localparam logic [1:0]      KEYS_V   = 2'(KEYS_NEEDED);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(HIT_COOLDOWN);

  state_e          state_q;
  todo_e           todo_q;
  logic [1:0]      key_find_q;
  logic [1:0]      heart_q;
  logic [3:0]      play_valid_q;
  logic [CD_W-1:0] cooldown_q;
  logic [1:0]      last_stage_q;

  // Stage codes are 2k (play) and 2k+1 (success), so bits [2:1] give k.
  logic [1:0] cur_k;
  logic [1:0] unlock_idx;
  logic       trap_ok;
  logic       enter_en;
  logic [1:0] enter_k;

  assign cur_k      = state_q[2:1];
  // Stage 3 wraps to index 0, which is the all-cleared bit.
  assign unlock_idx = cur_k + 2'd1;
  assign trap_ok    = bus.trap_hit && (cooldown_q == '0);

  // Every path into a stage shares the same entry load, so it is decided once.
  always_comb begin
    enter_en = 1'b0;
    enter_k  = last_stage_q;
    case (state_q)
      ST_TITLE:
        if (bus.stage_sel_pulse && (bus.stage_sel != 2'd0) && play_valid_q[bus.stage_sel]) begin
          enter_en = 1'b1;
          enter_k  = bus.stage_sel;
        end
      ST_SUCCESS1, ST_SUCCESS2:
        if (bus.next_pulse && !bus.back_pulse) begin
          enter_en = 1'b1;
          enter_k  = cur_k + 2'd1;
        end
      ST_FAIL:
        if (bus.retry_pulse && !bus.back_pulse) enter_en = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_TITLE;
      todo_q       <= TODO_NONE;
      key_find_q   <= 2'd0;
      heart_q      <= HEARTS_V;
      play_valid_q <= 4'b0010;
      cooldown_q   <= '0;
      last_stage_q <= 2'd1;
    end else if (enter_en) begin
      state_q      <= state_e'({1'b0, enter_k, 1'b0});
      todo_q       <= TODO_FIND_KEY;
      key_find_q   <= 2'd0;
      heart_q      <= HEARTS_V;
      cooldown_q   <= '0;
      last_stage_q <= enter_k;
    end else begin
      case (state_q)
        ST_TITLE:
          if (bus.staff_pulse) state_q <= ST_STAFF;
        ST_STAFF:
          if (bus.back_pulse) state_q <= ST_TITLE;
        ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
          if (bus.back_pulse) begin
            state_q    <= ST_TITLE;
            todo_q     <= TODO_NONE;
            cooldown_q <= '0;
          end else if (trap_ok && heart_q == 2'd1) begin
            state_q    <= ST_FAIL;
            heart_q    <= 2'd0;
            todo_q     <= TODO_NONE;
            cooldown_q <= '0;
          end else begin
            if (trap_ok) begin
              heart_q    <= heart_q - 2'd1;
              cooldown_q <= CD_LOAD;
            end else if (cooldown_q != '0) begin
              cooldown_q <= cooldown_q - 1'b1;
            end
            case (todo_q)
              TODO_FIND_KEY:
                if (bus.key_hit && key_find_q != KEYS_V) begin
                  key_find_q <= key_find_q + 2'd1;
                  if (key_find_q + 2'd1 == KEYS_V) todo_q <= TODO_FIND_LIGHT;
                end
              TODO_FIND_LIGHT:
                if (bus.light_hit) todo_q <= TODO_FIND_DOOR;
              TODO_FIND_DOOR:
                if (bus.door_hit) begin
                  state_q                  <= state_e'(state_q + 4'd1);
                  todo_q                   <= TODO_NONE;
                  cooldown_q               <= '0;
                  play_valid_q[unlock_idx] <= 1'b1;
                end
              default: ;
            endcase
          end
        end
        ST_SUCCESS1, ST_SUCCESS2:
          if (bus.back_pulse) state_q <= ST_TITLE;
        ST_SUCCESS3:
          if (bus.back_pulse)      state_q <= ST_TITLE;
          else if (bus.next_pulse) state_q <= ST_STAFF;
        ST_FAIL:
          if (bus.back_pulse) state_q <= ST_TITLE;
        default: begin
          state_q    <= ST_TITLE;
          todo_q     <= TODO_NONE;
          cooldown_q <= '0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.key_find   = key_find_q;
  assign bus.heart      = heart_q;
  assign bus.todo       = todo_q;
  assign bus.play_valid = play_valid_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios followed by
// random event traffic, compared every cycle against a screen-level model.
module tb_game_flow_ctrl;
  localparam int HEARTS = 3;
  localparam int KN     = 3;
  localparam int HC     = 4;
  localparam int CDW    = 3;

  logic clk;
  logic rst;
  game_flow_if bus();

  game_flow_ctrl #(
    .HEARTS(HEARTS), .KEYS_NEEDED(KN), .HIT_COOLDOWN(HC), .CD_W(CDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       sel_p;
    logic [1:0] sel;
    logic       staff, next, back, retry, key, light, door, trap;
  } ev_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Screen-level reference model.
  typedef enum {M_TITLE, M_STAFF, M_PLAY, M_WIN, M_FAIL} scr_e;
  scr_e     m_scr;
  int       m_k, m_keys, m_hearts, m_task, m_cd, m_last;
  bit [3:0] m_unlock;

  function automatic void m_enter(input int k);
    m_scr = M_PLAY; m_k = k; m_keys = 0; m_hearts = HEARTS;
    m_task = 1; m_cd = 0; m_last = k;
  endfunction

  function automatic void model(input ev_t e);
    bit hit;
    if (e.rst) begin
      m_scr = M_TITLE; m_keys = 0; m_hearts = HEARTS; m_task = 0;
      m_unlock = 4'b0010; m_cd = 0; m_last = 1; m_k = 1;
      return;
    end
    case (m_scr)
      M_TITLE:
        if (e.sel_p && e.sel != 0 && m_unlock[e.sel]) m_enter(int'(e.sel));
        else if (e.staff) m_scr = M_STAFF;
      M_STAFF:
        if (e.back) m_scr = M_TITLE;
      M_PLAY: begin
        hit = e.trap && (m_cd == 0);
        if (e.back) m_scr = M_TITLE;
        else if (hit && m_hearts == 1) begin
          m_hearts = 0;
          m_scr = M_FAIL;
        end else begin
          if (m_cd > 0) m_cd--;
          if (hit) begin m_hearts--; m_cd = HC; end
          if (m_task == 1 && e.key && m_keys < KN) begin
            m_keys++;
            if (m_keys == KN) m_task = 2;
          end else if (m_task == 2 && e.light) m_task = 3;
          else if (m_task == 3 && e.door) begin
            m_scr = M_WIN;
            m_unlock[(m_k == 3) ? 0 : m_k + 1] = 1'b1;
          end
        end
      end
      M_WIN:
        if (e.back) m_scr = M_TITLE;
        else if (e.next) begin
          if (m_k < 3) m_enter(m_k + 1);
          else m_scr = M_STAFF;
        end
      M_FAIL:
        if (e.back) m_scr = M_TITLE;
        else if (e.retry) m_enter(m_last);
      default: ;
    endcase
    if (m_scr != M_PLAY) begin m_task = 0; m_cd = 0; end
  endfunction

  function automatic logic [13:0] m_outputs();
    int st;
    case (m_scr)
      M_TITLE: st = 0;
      M_STAFF: st = 1;
      M_PLAY:  st = 2 * m_k;
      M_WIN:   st = 2 * m_k + 1;
      default: st = 8;
    endcase
    return {4'(st), 2'(m_keys), 2'(m_hearts), 2'(m_task), m_unlock};
  endfunction

  function automatic logic [13:0] dut_outputs();
    return {bus.state, bus.key_find, bus.heart, bus.todo, bus.play_valid};
  endfunction

  task automatic drive(input ev_t e);
    rst                 = e.rst;
    bus.stage_sel_pulse = e.sel_p;
    bus.stage_sel       = e.sel;
    bus.staff_pulse     = e.staff;
    bus.next_pulse      = e.next;
    bus.back_pulse      = e.back;
    bus.retry_pulse     = e.retry;
    bus.key_hit         = e.key;
    bus.light_hit       = e.light;
    bus.door_hit        = e.door;
    bus.trap_hit        = e.trap;
  endtask

  // One clock: apply events, advance the model, compare #1 after the edge.
  task automatic cycle(input ev_t e);
    drive(e);
    @(posedge clk);
    model(e);
    #1;
    drive('0);
    check("model", 32'(dut_outputs()), 32'(m_outputs()));
  endtask

  task automatic act(input string what, input int k = 0);
    ev_t e;
    e = '0;
    case (what)
      "rst":      e.rst = 1'b1;
      "sel":      begin e.sel_p = 1'b1; e.sel = 2'(k); end
      "selstaff": begin e.sel_p = 1'b1; e.sel = 2'(k); e.staff = 1'b1; end
      "staff":    e.staff = 1'b1;
      "next":     e.next = 1'b1;
      "back":     e.back = 1'b1;
      "retry":    e.retry = 1'b1;
      "key":      e.key = 1'b1;
      "light":    e.light = 1'b1;
      "door":     e.door = 1'b1;
      "trap":     e.trap = 1'b1;
      "trapkey":  begin e.trap = 1'b1; e.key = 1'b1; end
      "trapdoor": begin e.trap = 1'b1; e.door = 1'b1; end
      default: ;
    endcase
    cycle(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) act("idle");
  endtask

  task automatic expect_out(input string tag, input int st, input int kf,
                            input int ht, input int td, input int pv);
    check(tag, 32'(dut_outputs()), 32'({4'(st), 2'(kf), 2'(ht), 2'(td), 4'(pv)}));
  endtask

  task automatic clear_stage();
    act("key"); act("key"); act("key"); act("light"); act("door");
  endtask

  initial begin
    drive('0);
    rst = 1'b1;

    act("rst");              expect_out("reset", 0, 0, 3, 0, 4'b0010);
    act("sel", 2);           expect_out("locked_sel", 0, 0, 3, 0, 4'b0010);
    act("sel", 0);           expect_out("sel_zero", 0, 0, 3, 0, 4'b0010);
    act("sel", 1);           expect_out("enter_s1", 2, 0, 3, 1, 4'b0010);
    act("door");             expect_out("early_door", 2, 0, 3, 1, 4'b0010);
    act("key");              expect_out("key1", 2, 1, 3, 1, 4'b0010);
    act("key");              expect_out("key2", 2, 2, 3, 1, 4'b0010);
    act("key");              expect_out("key3", 2, 3, 3, 2, 4'b0010);
    act("key");              expect_out("key4_ign", 2, 3, 3, 2, 4'b0010);
    act("light");            expect_out("light", 2, 3, 3, 3, 4'b0010);
    act("door");             expect_out("door_s1", 3, 3, 3, 0, 4'b0110);

    act("next");             expect_out("enter_s2", 4, 0, 3, 1, 4'b0110);
    act("trap");             expect_out("trap_t0", 4, 0, 2, 1, 4'b0110);
    act("idle");
    act("trap");             expect_out("trap_cool", 4, 0, 2, 1, 4'b0110);
    idle(2);
    act("trap");             expect_out("trap_t5", 4, 0, 1, 1, 4'b0110);
    idle(5);
    act("trap");             expect_out("trap_fatal", 8, 0, 0, 0, 4'b0110);
    act("retry");            expect_out("retry", 4, 0, 3, 1, 4'b0110);

    act("trapkey");          expect_out("trap_key", 4, 1, 2, 1, 4'b0110);
    idle(5);
    act("trap");             expect_out("trap2", 4, 1, 1, 1, 4'b0110);
    act("key"); act("key"); act("light");
    act("idle");
    act("trapdoor");         expect_out("fatal_door", 8, 3, 0, 0, 4'b0110);

    act("retry");
    clear_stage();           expect_out("clear_s2", 5, 3, 3, 0, 4'b1110);
    act("next");             expect_out("enter_s3", 6, 0, 3, 1, 4'b1110);
    clear_stage();           expect_out("clear_s3", 7, 3, 3, 0, 4'b1111);
    act("next");             expect_out("s3_next", 1, 3, 3, 0, 4'b1111);
    act("back");             expect_out("staff_back", 0, 3, 3, 0, 4'b1111);
    act("selstaff", 3);      expect_out("sel_wins", 6, 0, 3, 1, 4'b1111);
    act("back");             expect_out("stage_back", 0, 0, 3, 0, 4'b1111);
    act("rst");              expect_out("rst_pv", 0, 0, 3, 0, 4'b0010);

    act("sel", 1);
    act("key"); act("key");
    act("trap");
    idle(5);
    act("trap");             expect_out("mid_pre", 2, 2, 1, 1, 4'b0010);
    act("rst");              expect_out("mid_rst", 0, 0, 3, 0, 4'b0010);

    for (int i = 0; i < 4000; i++) begin
      ev_t e;
      e.rst   = ($urandom_range(0, 399) == 0);
      e.sel_p = ($urandom_range(0, 2) == 0);
      e.sel   = 2'($urandom_range(0, 3));
      e.staff = ($urandom_range(0, 5) == 0);
      e.next  = ($urandom_range(0, 3) == 0);
      e.back  = ($urandom_range(0, 15) == 0);
      e.retry = ($urandom_range(0, 3) == 0);
      e.key   = ($urandom_range(0, 2) == 0);
      e.light = ($urandom_range(0, 2) == 0);
      e.door  = ($urandom_range(0, 2) == 0);
      e.trap  = ($urandom_range(0, 5) == 0);
      cycle(e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Game-level sequencer that drives the UI overlay renderer and the play-field logic. It holds the screen state, which is one of title, staff, stage 1-3, success 1-3 or fail. It also tracks stage progress (keys found, current task), remaining hearts and the stage-unlock mask, and updates them from one-cycle event pulses produced by the button/mouse decoder and the collision logic. All outputs are registered and feed the overlay renderer directly (state, key_find, heart, todo, play_valid).

Parameters:
HEARTS, 3, hearts loaded on stage entry (1..3)
KEYS_NEEDED, 3, keys required before the task advances to FIND_LIGHT (1..3)
HIT_COOLDOWN, 50000000, cycles of trap immunity after a non-fatal hit
CD_W, 26, cooldown counter width; must hold HIT_COOLDOWN

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stage_sel_pulse  in  1  title-screen stage button clicked
stage_sel  in  2  selected stage, 1..3; sampled with stage_sel_pulse
staff_pulse  in  1  staff button clicked
next_pulse  in  1  next button clicked
back_pulse  in  1  back button clicked
retry_pulse  in  1  retry button clicked
key_hit  in  1  player touched a key
light_hit  in  1  player touched the light
door_hit  in  1  player reached the door
trap_hit  in  1  player touched a trap
state  out  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8
key_find  out  2  keys collected in the current stage
heart  out  2  remaining hearts
todo  out  2  NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3
play_valid  out  4  bit1 stage1 unlocked (always 1), bit2 stage2, bit3 stage3, bit0 all cleared

Behaviour:
- Registered outputs: every input pulse takes effect on the next rising edge of clk (1-cycle latency). Input pulses are one cycle wide and are not latched.
- Reset values: state=TITLE, key_find=0, heart=HEARTS, todo=NONE, play_valid=4'b0010, cooldown=0, last_stage=1. rst mid-stage aborts the stage immediately. rst is the only way to clear play_valid.
- Stage entry from any path (stage k): key_find=0, heart=HEARTS, todo=FIND_KEY, cooldown=0, last_stage=k.
- TITLE:
  - stage_sel_pulse enters stage k only if stage_sel=k and play_valid[k]=1.
  - stage_sel=0 or a locked stage is ignored.
  - staff_pulse -> STAFF. If staff_pulse and stage_sel_pulse occur together, stage_sel_pulse wins.
- STAFF: back_pulse -> TITLE.
- STAGEk event priority (highest first):
  1. back_pulse -> TITLE.
  2. Fatal trap -> FAIL.
  3. Progress event.
- Trap handling:
  - trap_hit is accepted only when cooldown=0.
  - If heart=1, state -> FAIL and heart=0.
  - Otherwise heart decrements and cooldown loads HIT_COOLDOWN.
  - A trap and a progress event in the same cycle: a non-fatal trap and the progress event both take effect; a fatal trap discards the progress event.
- Progress events (only the event matching todo counts; all others are ignored):
  - FIND_KEY: key_hit increments key_find. When the new value equals KEYS_NEEDED, todo=FIND_LIGHT in the same update. key_find saturates.
  - FIND_LIGHT: light_hit -> todo=FIND_DOOR.
  - FIND_DOOR: door_hit -> SUCCESSk, and sets play_valid[k+1] (k=3 sets bit0).
- Cooldown: decrements by 1 each cycle while nonzero in STAGEk. It is forced to 0 outside stage states.
- SUCCESS1/SUCCESS2:
  - next_pulse enters stage k+1.
  - back_pulse -> TITLE; back_pulse wins if it occurs together with next_pulse.
- SUCCESS3: next_pulse -> STAFF; back_pulse -> TITLE.
- FAIL:
  - retry_pulse re-enters last_stage.
  - back_pulse -> TITLE; back_pulse wins if it occurs together with retry_pulse.
- todo=NONE in TITLE, STAFF, SUCCESSk and FAIL. key_find and heart hold their last stage values in SUCCESSk and FAIL so the overlay can show them. TITLE and STAFF also hold them.
- Undefined state codes (9..15) return to TITLE on the next cycle with the entry values of TITLE.
- Pulses of events that are not legal in the current state have no effect.

Test Plan:
- Reset, then stage_sel_pulse with stage_sel=2 -> state stays 0, play_valid=4'b0010; stage_sel=1 -> state=2, heart=3, key_find=0, todo=1.
- In STAGE1: 3 key_hit, light_hit, door_hit -> key_find 1,2,3 with todo=2 after the third key; then todo=3; then state=3, play_valid=4'b0110. A 4th key_hit is ignored. door_hit while todo=1 is ignored.
- HIT_COOLDOWN=4: trap_hit at t0 -> heart=2. trap_hit at t0+2 is ignored. trap_hit at t0+5 -> heart=1. trap_hit after cooldown expires -> state=8, heart=0. retry_pulse -> state=2, heart=3, key_find=0.
- Fatal trap_hit and door_hit in the same cycle -> state=8, play_valid unchanged. Non-fatal trap_hit and key_hit together -> heart-1 and key_find+1.
- Clear all three stages via next_pulse -> play_valid=4'b1111, then next_pulse -> state=1, back_pulse -> state=0. Then rst -> play_valid=4'b0010.
- rst asserted mid-stage with key_find=2, heart=1 -> next cycle state=0, key_find=0, heart=3, todo=0.
